// File: rtl/duty_compensator_if.sv
// duty_compensator_if
// Groups the sample/coefficient/limit inputs and the duty command outputs of
// the digital compensator that feeds a DPWM.
//   start    : one-cycle strobe, new error sample available on e
//   e        : signed error sample (EW bits)
//   a, b, c  : signed Q.FRAC coefficients for e[n], e[n-1], e[n-2] (CW bits)
//   dmin/dmax: unsigned duty limits (WIDTH bits)
//   d        : registered duty command (WIDTH bits)
//   d_valid  : one-cycle pulse after d is updated
//   busy     : compensator is computing
//   overrun  : one-cycle pulse, a start arrived while busy and was dropped
// The master modport is the sample source (controller / bench); the slave
// modport is the compensator itself.
interface duty_compensator_if #(
    parameter int WIDTH = 12,
    parameter int EW    = 10,
    parameter int CW    = 12
) ();
    logic                    start;
    logic signed [EW-1:0]    e;
    logic signed [CW-1:0]    a;
    logic signed [CW-1:0]    b;
    logic signed [CW-1:0]    c;
    logic        [WIDTH-1:0] dmin;
    logic        [WIDTH-1:0] dmax;
    logic        [WIDTH-1:0] d;
    logic                    d_valid;
    logic                    busy;
    logic                    overrun;

    modport master (
        output start, e, a, b, c, dmin, dmax,
        input  d, d_valid, busy, overrun
    );

    modport slave (
        input  start, e, a, b, c, dmin, dmax,
        output d, d_valid, busy, overrun
    );
endinterface

// File: rtl/duty_compensator.sv
// duty_compensator
// Incremental PID-style compensator for a DPWM:
//   u[n] = u[n-1] + a*e[n] + b*e[n-1] + c*e[n-2]
// evaluated over three cycles with one shared signed multiplier, followed by
// a saturation cycle that clamps the integer part of the accumulator to
// [dmin, dmax] and applies anti-windup to the stored u.
// Ports:
//   hfclk : clock, all state changes on its rising edge
//   reset : asynchronous active-low reset
//   bus   : duty_compensator_if slave (start/e/a/b/c/dmin/dmax in,
//           d/d_valid/busy/overrun out)
// Latency: start sampled at edge k -> d updated and d_valid high after k+4.
module duty_compensator #(
    parameter int WIDTH = 12,
    parameter int EW    = 10,
    parameter int CW    = 12,
    parameter int FRAC  = 8
) (
    input  logic              hfclk,
    input  logic              reset,
    duty_compensator_if.slave bus
);

    // Accumulator / u width, product width, and a sum width wide enough that
    // acc + product can never wrap before the saturation check.
    localparam int AW = WIDTH + FRAC + 2;
    localparam int PW = EW + CW;
    localparam int SW = ((AW > PW) ? AW : PW) + 1;
    // Integer part of the accumulator (signed).
    localparam int QW = AW - FRAC;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        SAT  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // e_hist_reg[0] = e[n] (latched on accept), [1] = e[n-1], [2] = e[n-2]
    logic [2:0][EW-1:0]    e_hist_reg;
    logic signed [AW-1:0]  acc_reg;
    logic signed [AW-1:0]  u_reg;
    logic [WIDTH-1:0]      d_reg;
    logic                  d_valid_reg;
    logic                  overrun_reg;

    logic                  busy;
    logic                  accept;
    logic                  in_sat;
    logic                  in_mac;
    logic signed [CW-1:0]  mul_coef;
    logic signed [EW-1:0]  mul_data;
    logic signed [AW-1:0]  acc_base;

    logic signed [PW-1:0]  product;
    logic signed [SW-1:0]  sum;
    logic                  sum_ovf;
    logic signed [AW-1:0]  sum_sat;

    logic signed [QW-1:0]  q;
    logic signed [QW-1:0]  dmin_ext;
    logic signed [QW-1:0]  dmax_ext;
    logic signed [QW-1:0]  q_hi;
    logic signed [QW-1:0]  q_clamped;
    logic                  clamped;
    logic signed [AW-1:0]  u_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge hfclk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Only IDLE looks at start; the MAC/SAT sequence is
    // fixed-length and cannot be interrupted except by reset.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = bus.start ? M0 : IDLE;
            M0:      state_next = M1;
            M1:      state_next = M2;
            M2:      state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Steers the shared multiplier: M0 starts from u, M1/M2
    // continue from acc. Coefficients are read live in their own state.
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_reg != IDLE);
        accept   = (state_reg == IDLE) && bus.start;
        in_sat   = (state_reg == SAT);
        in_mac   = 1'b0;
        mul_coef = '0;
        mul_data = '0;
        acc_base = '0;
        case (state_reg)
            M0: begin
                in_mac   = 1'b1;
                mul_coef = bus.a;
                mul_data = $signed(e_hist_reg[0]);
                acc_base = u_reg;
            end
            M1: begin
                in_mac   = 1'b1;
                mul_coef = bus.b;
                mul_data = $signed(e_hist_reg[1]);
                acc_base = acc_reg;
            end
            M2: begin
                in_mac   = 1'b1;
                mul_coef = bus.c;
                mul_data = $signed(e_hist_reg[2]);
                acc_base = acc_reg;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared multiplier and saturating accumulate
    // ------------------------------------------------------------------
    assign product = PW'(mul_coef) * PW'(mul_data);
    assign sum     = SW'(acc_base) + SW'(product);

    // The sum fits in AW bits only if all bits from AW-1 upward agree.
    assign sum_ovf = (sum[SW-1:AW-1] != {(SW-AW+1){sum[SW-1]}});
    assign sum_sat = !sum_ovf ? sum[AW-1:0]
                   : (sum[SW-1] ? {1'b1, {(AW-1){1'b0}}}
                                : {1'b0, {(AW-1){1'b1}}});

    // ------------------------------------------------------------------
    // Saturation stage. Dropping the FRAC bits of a two's complement value
    // is an arithmetic shift, i.e. truncation toward minus infinity.
    // dmax is applied first and dmin second, so dmin wins if they cross.
    // ------------------------------------------------------------------
    assign q         = acc_reg[AW-1:FRAC];
    assign dmin_ext  = $signed({{(QW-WIDTH){1'b0}}, bus.dmin});
    assign dmax_ext  = $signed({{(QW-WIDTH){1'b0}}, bus.dmax});
    assign q_hi      = (q > dmax_ext) ? dmax_ext : q;
    assign q_clamped = (q_hi < dmin_ext) ? dmin_ext : q_hi;
    assign clamped   = (q_clamped != q);
    // Anti-windup: when the output is limited, u restarts from the limit
    // instead of carrying the excess forward.
    assign u_next    = clamped ? {q_clamped, {FRAC{1'b0}}} : acc_reg;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge hfclk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
        end else if (in_mac) begin
            acc_reg <= sum_sat;
        end
    end

    always_ff @(posedge hfclk or negedge reset) begin
        if (!reset) begin
            e_hist_reg <= '0;
        end else begin
            if (accept) begin
                e_hist_reg[0] <= bus.e;
            end
            if (in_sat) begin
                e_hist_reg[2] <= e_hist_reg[1];
                e_hist_reg[1] <= e_hist_reg[0];
            end
        end
    end

    always_ff @(posedge hfclk or negedge reset) begin
        if (!reset) begin
            u_reg       <= '0;
            d_reg       <= '0;
            d_valid_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            d_valid_reg <= in_sat;
            // busy includes SAT, so a start there is also dropped.
            overrun_reg <= bus.start && busy;
            if (in_sat) begin
                d_reg <= q_clamped[WIDTH-1:0];
                u_reg <= u_next;
            end
        end
    end

    assign bus.d       = d_reg;
    assign bus.d_valid = d_valid_reg;
    assign bus.busy    = busy;
    assign bus.overrun = overrun_reg;

endmodule
